// File: rtl/keypad_input_reg_pkg.sv
// Shared scanner state, key codes and the keypad row/column to key map.
// Pure declarations; no latency, no backpressure.
package keypad_input_reg_pkg;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2
    } scan_state_t;

    typedef logic [3:0] key_code_t;

    localparam key_code_t KEY_0    = 4'd0;
    localparam key_code_t KEY_1    = 4'd1;
    localparam key_code_t KEY_2    = 4'd2;
    localparam key_code_t KEY_3    = 4'd3;
    localparam key_code_t KEY_4    = 4'd4;
    localparam key_code_t KEY_5    = 4'd5;
    localparam key_code_t KEY_6    = 4'd6;
    localparam key_code_t KEY_7    = 4'd7;
    localparam key_code_t KEY_8    = 4'd8;
    localparam key_code_t KEY_9    = 4'd9;
    localparam key_code_t KEY_A    = 4'd10;
    localparam key_code_t KEY_B    = 4'd11;
    localparam key_code_t KEY_C    = 4'd12;
    localparam key_code_t KEY_D    = 4'd13;
    localparam key_code_t KEY_STAR = 4'd14;
    localparam key_code_t KEY_HASH = 4'd15;

    // True when exactly one active-low row line is pulled down.
    function automatic logic single_low(input logic [3:0] row_n);
        return (row_n == 4'b1110) || (row_n == 4'b1101) ||
               (row_n == 4'b1011) || (row_n == 4'b0111);
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] row_n);
        case (row_n)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic key_code_t key_lookup(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'd0:    return KEY_1;
            4'd1:    return KEY_2;
            4'd2:    return KEY_3;
            4'd3:    return KEY_A;
            4'd4:    return KEY_4;
            4'd5:    return KEY_5;
            4'd6:    return KEY_6;
            4'd7:    return KEY_B;
            4'd8:    return KEY_7;
            4'd9:    return KEY_8;
            4'd10:   return KEY_9;
            4'd11:   return KEY_C;
            4'd12:   return KEY_STAR;
            4'd13:   return KEY_0;
            4'd14:   return KEY_HASH;
            default: return KEY_D;
        endcase
    endfunction

endpackage

// File: rtl/keypad_input_reg_if.sv
// Key event channel from the scanner to the entry/handshake logic.
// Single-cycle pulse, no backpressure: the consumer must act in that cycle.
interface keypad_input_reg_if;
    import keypad_input_reg_pkg::*;

    logic      key_valid;
    key_code_t key_code;

    modport master (output key_valid, output key_code);
    modport slave  (input  key_valid, input  key_code);
endinterface

// File: rtl/keypad_scanner.sv
// Column scanner with row synchronizer, tick divider and press/release debounce.
// key_valid is combinational during the accepting tick; no backpressure.
module keypad_scanner
    import keypad_input_reg_pkg::*;
#(
    parameter int CLK_DIV        = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           row,
    output logic [3:0]           col,
    keypad_input_reg_if.master   key_bus
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    scan_state_t      state;
    scan_state_t      state_nxt;
    logic [1:0]       col_idx;
    logic [1:0]       col_idx_nxt;
    logic [3:0]       row_cap;
    logic [3:0]       row_cap_nxt;
    logic [CNT_W-1:0] stable_cnt;
    logic [CNT_W-1:0] stable_cnt_nxt;
    logic             key_hit;

    // Rows idle high, so the synchronizer resets to "no key".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SCAN;
            col_idx    <= 2'd0;
            row_cap    <= 4'b1111;
            stable_cnt <= '0;
        end else begin
            state      <= state_nxt;
            col_idx    <= col_idx_nxt;
            row_cap    <= row_cap_nxt;
            stable_cnt <= stable_cnt_nxt;
        end
    end

    // stable_cnt counts matching ticks in PRESS and idle ticks in RELEASE.
    always_comb begin
        state_nxt      = state;
        col_idx_nxt    = col_idx;
        row_cap_nxt    = row_cap;
        stable_cnt_nxt = stable_cnt;
        key_hit        = 1'b0;
        if (tick) begin
            case (state)
                SCAN: begin
                    if (single_low(row_sync)) begin
                        row_cap_nxt    = row_sync;
                        stable_cnt_nxt = '0;
                        state_nxt      = PRESS;
                    end else begin
                        col_idx_nxt = col_idx + 2'd1;
                    end
                end
                PRESS: begin
                    if (row_sync == row_cap) begin
                        if (stable_cnt == CNT_LAST) begin
                            key_hit        = 1'b1;
                            stable_cnt_nxt = '0;
                            state_nxt      = RELEASE;
                        end else begin
                            stable_cnt_nxt = stable_cnt + CNT_W'(1);
                        end
                    end else begin
                        state_nxt = SCAN;
                    end
                end
                RELEASE: begin
                    if (row_sync == 4'b1111) begin
                        if (stable_cnt == CNT_LAST) begin
                            stable_cnt_nxt = '0;
                            state_nxt      = SCAN;
                        end else begin
                            stable_cnt_nxt = stable_cnt + CNT_W'(1);
                        end
                    end else begin
                        stable_cnt_nxt = '0;
                    end
                end
                default: state_nxt = SCAN;
            endcase
        end
    end

    assign col               = ~(4'b0001 << col_idx);
    assign key_bus.key_valid = key_hit;
    assign key_bus.key_code  = key_lookup(row_index(row_cap), col_idx);

endmodule

// File: rtl/keypad_input_reg.sv
// Keypad decimal entry register with CPU read handshake and overrun flag.
// Key actions land one cycle after the accepting tick; RE acts on the next edge.
module keypad_input_reg
    import keypad_input_reg_pkg::*;
#(
    parameter int CLK_DIV        = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    input  logic       RE,
    output logic [7:0] IR_OUT,
    output logic       IR_VALID,
    output logic       OVERRUN,
    output logic [7:0] ENTRY
);

    keypad_input_reg_if key_bus ();

    keypad_scanner #(
        .CLK_DIV        (CLK_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_scanner (
        .clk     (CLK),
        .rst_n   (RESET),
        .row     (ROW),
        .col     (COL),
        .key_bus (key_bus)
    );

    logic [11:0] entry_x10;
    logic [7:0]  entry_nxt;
    logic [7:0]  ir_out_nxt;
    logic        ir_valid_nxt;
    logic        overrun_nxt;

    // Wide enough for 255*10+9 so overflow is detected, not wrapped.
    assign entry_x10 = ({4'd0, ENTRY} * 12'd10) + {8'd0, key_bus.key_code};

    always_comb begin
        entry_nxt    = ENTRY;
        ir_out_nxt   = IR_OUT;
        ir_valid_nxt = IR_VALID;
        overrun_nxt  = OVERRUN;
        if (RE && IR_VALID) begin
            ir_valid_nxt = 1'b0;
            overrun_nxt  = 1'b0;
        end
        if (key_bus.key_valid) begin
            if (key_bus.key_code <= KEY_9) begin
                if (entry_x10 <= 12'd255) begin
                    entry_nxt = entry_x10[7:0];
                end
            end else if (key_bus.key_code == KEY_STAR) begin
                entry_nxt = 8'd0;
            end else if (key_bus.key_code == KEY_HASH) begin
                ir_out_nxt   = ENTRY;
                ir_valid_nxt = 1'b1;
                entry_nxt    = 8'd0;
                // A same-cycle read consumes the old value, so no overrun.
                if (IR_VALID && !RE) begin
                    overrun_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ENTRY    <= 8'd0;
            IR_OUT   <= 8'd0;
            IR_VALID <= 1'b0;
            OVERRUN  <= 1'b0;
        end else begin
            ENTRY    <= entry_nxt;
            IR_OUT   <= ir_out_nxt;
            IR_VALID <= ir_valid_nxt;
            OVERRUN  <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_keypad_input_reg.sv
// Bench for keypad_input_reg: emulated matrix keypad, decimal-entry reference model,
// per-cycle output comparison plus directed literal expectations.
module tb_keypad_input_reg;

    localparam int CLK_DIV = 4;
    localparam int DEB     = 2;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [3:0] ROW;
    logic [3:0] COL;
    logic       RE = 1'b0;
    logic [7:0] IR_OUT;
    logic       IR_VALID;
    logic       OVERRUN;
    logic [7:0] ENTRY;

    keypad_input_reg_if exp_if ();

    keypad_input_reg #(
        .CLK_DIV        (CLK_DIV),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ROW      (ROW),
        .COL      (COL),
        .RE       (RE),
        .IR_OUT   (IR_OUT),
        .IR_VALID (IR_VALID),
        .OVERRUN  (OVERRUN),
        .ENTRY    (ENTRY)
    );

    always #5 CLK = ~CLK;

    // Physical keypad: a held key connects its row to its column line.
    logic key_down = 1'b0;
    int   key_r = 0;
    int   key_c = 0;
    logic bounce = 1'b0;

    always_comb begin
        ROW = 4'b1111;
        if (key_down && COL[key_c] == 1'b0) ROW[key_r] = 1'b0;
        if (bounce) ROW[1] = 1'b0;
    end

    string keymap = "123A456B789C*0#D";

    int m_entry = 0;
    int m_ir    = 0;
    bit m_valid = 1'b0;
    bit m_ovr   = 1'b0;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    initial begin
        exp_if.key_valid = 1'b0;
        exp_if.key_code  = 4'd0;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference behaviour of one accepted key (idx<0: RE-only cycle).
    task automatic m_apply(input byte k, input bit re, input int idx);
        bit v0;
        int t;
        v0 = m_valid;
        if (re && v0) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        if (idx >= 0) begin
            exp_if.key_valid = 1'b1;
            exp_if.key_code  = 4'(idx);
            if (k >= "0" && k <= "9") begin
                t = m_entry * 10 + int'(k - "0");
                if (t <= 255) m_entry = t;
            end else if (k == "*") begin
                m_entry = 0;
            end else if (k == "#") begin
                m_ir    = m_entry;
                m_entry = 0;
                m_valid = 1'b1;
                if (v0 && !re) m_ovr = 1'b1;
            end
        end
    endtask

    always @(negedge CLK) begin
        if (cmp_en) begin
            checks++;
            if ({ENTRY, IR_OUT, IR_VALID, OVERRUN} !== {m_entry[7:0], m_ir[7:0], m_valid, m_ovr}) begin
                failures++;
                $display("FAIL outputs t=%0t actual entry=%0d ir_out=%0d valid=%0b overrun=%0b required entry=%0d ir_out=%0d valid=%0b overrun=%0b last_key_pos=%0d",
                         $time, ENTRY, IR_OUT, IR_VALID, OVERRUN, m_entry, m_ir, m_valid, m_ovr,
                         exp_if.key_valid ? int'(exp_if.key_code) : -1);
            end
            checks++;
            if ($countones(~COL) != 1 || (!RESET && COL != 4'b1110)) begin
                failures++;
                $display("FAIL col_drive actual=%b required=one low bit (1110 in reset)", COL);
            end
        end
    end

    task automatic wait_col_enter(input int c, output bit ok);
        logic [3:0] tgt;
        logic [3:0] prev;
        tgt = ~(4'b0001 << c);
        ok  = 1'b0;
        @(negedge CLK);
        prev = COL;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (COL == tgt && prev != tgt) begin
                ok = 1'b1;
                break;
            end
            prev = COL;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL col_enter actual=timeout required=column %0d driven", c);
        end
    endtask

    // Press once the scan is one column before the key so the accepting tick is known.
    task automatic press(input byte k, input int hold, input bit re_ev);
        int idx;
        int c;
        bit ok;
        idx = -1;
        for (int i = 0; i < 16; i++) if (keymap[i] == k) idx = i;
        c = idx % 4;
        wait_col_enter((c + 3) % 4, ok);
        if (!ok) return;
        key_r    = idx / 4;
        key_c    = c;
        key_down = 1'b1;
        wait_col_enter(c, ok);
        if (!ok) begin
            key_down = 1'b0;
            return;
        end
        repeat (CLK_DIV * (1 + DEB) - 1) @(posedge CLK);
        #1 RE = re_ev;
        @(posedge CLK);
        m_apply(k, re_ev, idx);
        #1 RE = 1'b0;
        repeat (hold * CLK_DIV) @(posedge CLK);
        #1 key_down = 1'b0;
        repeat (CLK_DIV * (DEB + 3)) @(posedge CLK);
    endtask

    task automatic pulse_re();
        @(posedge CLK);
        #1 RE = 1'b1;
        @(posedge CLK);
        m_apply(" ", 1'b1, -1);
        #1 RE = 1'b0;
    endtask

    task automatic chk_out(input string name, input int act, input int exp);
        chk(name, act, exp);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_entry", ENTRY, 0);
        chk("reset_ir_out", IR_OUT, 0);
        chk("reset_valid", IR_VALID, 0);
        chk("reset_overrun", OVERRUN, 0);
        chk("reset_col", COL, 4'b1110);
        cmp_en = 1'b1;
        RESET  = 1'b1;

        press("1", 0, 0);  @(negedge CLK); chk("entry_1", ENTRY, 1);
        press("2", 0, 0);  @(negedge CLK); chk("entry_12", ENTRY, 12);
        press("8", 0, 0);  @(negedge CLK); chk("entry_128", ENTRY, 128);
        press("#", 0, 0);  @(negedge CLK);
        chk("hash_ir_128", IR_OUT, 128);
        chk("hash_valid", IR_VALID, 1);
        chk("hash_entry_clr", ENTRY, 0);
        pulse_re();        @(negedge CLK); chk("re_clears_valid", IR_VALID, 0);

        press("2", 0, 0);
        press("5", 0, 0);
        press("6", 0, 0);  @(negedge CLK); chk("overflow_ignored", ENTRY, 25);
        press("5", 0, 0);  @(negedge CLK); chk("entry_255", ENTRY, 255);
        press("#", 0, 0);  @(negedge CLK); chk("ir_255", IR_OUT, 255);
        pulse_re();

        // One-tick bounce on row 1 while column 1 is scanned would read as '5'.
        wait_col_enter(1, ok);
        @(posedge CLK); #1 bounce = 1'b1;
        repeat (CLK_DIV) @(posedge CLK);
        #1 bounce = 1'b0;
        repeat (CLK_DIV * 4) @(posedge CLK);
        @(negedge CLK); chk("bounce_no_event", ENTRY, 0);
        press("5", 20, 0); @(negedge CLK); chk("held_once", ENTRY, 5);

        press("*", 0, 0);  @(negedge CLK); chk("star_clear", ENTRY, 0);
        press("7", 0, 0);
        press("#", 0, 0);  @(negedge CLK); chk("first_ovr", OVERRUN, 0);
        press("9", 0, 0);
        press("#", 0, 0);  @(negedge CLK);
        chk("ovr_ir_9", IR_OUT, 9);
        chk("ovr_valid", IR_VALID, 1);
        chk("ovr_set", OVERRUN, 1);
        pulse_re();        @(negedge CLK);
        chk("ovr_re_valid", IR_VALID, 0);
        chk("ovr_re_clear", OVERRUN, 0);

        press("1", 0, 0);
        press("#", 0, 0);
        press("3", 0, 0);
        press("#", 0, 1);  @(negedge CLK);
        chk("same_cycle_ir", IR_OUT, 3);
        chk("same_cycle_valid", IR_VALID, 1);
        chk("same_cycle_ovr", OVERRUN, 0);

        press("6", 0, 0);  @(negedge CLK); chk("pre_reset_entry", ENTRY, 6);
        // Key '4' is row 1, column 0: reset lands after capture, before acceptance.
        wait_col_enter(3, ok);
        key_r = 1; key_c = 0; key_down = 1'b1;
        wait_col_enter(0, ok);
        repeat (CLK_DIV + 2) @(posedge CLK);
        #1 RESET = 1'b0;
        m_entry = 0; m_ir = 0; m_valid = 1'b0; m_ovr = 1'b0;
        #1;
        chk("mid_reset_entry", ENTRY, 0);
        chk("mid_reset_ir", IR_OUT, 0);
        chk("mid_reset_valid", IR_VALID, 0);
        chk("mid_reset_ovr", OVERRUN, 0);
        chk("mid_reset_col", COL, 4'b1110);
        repeat (3) @(posedge CLK);
        #1 key_down = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;
        repeat (CLK_DIV * 12) @(posedge CLK);
        @(negedge CLK); chk("no_event_after_reset", ENTRY, 0);

        for (int n = 0; n < 40; n++) begin
            byte k;
            k = keymap[$urandom_range(15)];
            press(k, int'($urandom_range(3)), $urandom_range(3) == 0);
            if ($urandom_range(3) == 0) pulse_re();
        end

        @(negedge CLK);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_input_reg.md
KEYPAD_INPUT_REG -- requirements
Module: keypad_input_reg

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1000: CLK cycles per scan tick, minimum 2.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4: consecutive stable ticks needed to accept a press or a release, minimum 1.
REQ-003 SHALL have port CLK  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ROW  input  4  keypad rows, active-low, pulled up externally, asynchronous to CLK.
REQ-006 SHALL have port COL  output  4  keypad column drive, active-low, exactly one bit low at any time.
REQ-007 SHALL have port RE  input  1  CPU read acknowledge of IR_OUT.
REQ-008 SHALL have port IR_OUT  output  8  last entered value presented to the CPU.
REQ-009 SHALL have port IR_VALID  output  1  IR_OUT holds an unread value.
REQ-010 SHALL have port OVERRUN  output  1  sticky flag: an unread value was overwritten.
REQ-011 SHALL have port ENTRY  output  8  in-progress accumulator, for echo on the 7-segment output register.

Function
REQ-012 SHALL pass ROW through a two-flop synchronizer before any use.
REQ-013 SHALL generate a one-cycle scan tick every CLK_DIV cycles from a free-running divider.
REQ-014 SHALL drive COL = ~(1 << col), where col is a 2-bit column index.
REQ-015 SHALL run a scanner FSM with states SCAN, PRESS, RELEASE.
REQ-016 In SCAN, on each tick: if synchronized ROW == 4'b1111, col SHALL advance by one, wrapping 3 -> 0; if exactly one ROW bit is low, the FSM SHALL capture the row, hold col, clear the stable counter and enter PRESS.
REQ-017 In SCAN, when more than one ROW bit is low, the FSM SHALL treat it as no key and advance col.
REQ-018 In PRESS, on each tick: a ROW value equal to the captured one SHALL increment the stable counter; any other ROW value SHALL return the FSM to SCAN without an event.
REQ-019 In PRESS, when the stable counter reaches DEBOUNCE_SCANS, the FSM SHALL emit exactly one key event and enter RELEASE.
REQ-020 In RELEASE, col SHALL be held; DEBOUNCE_SCANS consecutive ticks with ROW == 4'b1111 SHALL return the FSM to SCAN, and any other value SHALL restart that count. A held key therefore never repeats.
REQ-021 Key map by (row, col): r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: * 0 # D.
REQ-022 On digit d, ENTRY SHALL become ENTRY*10+d, computed at 12 bits; when the result exceeds 255 the digit SHALL be ignored and ENTRY kept.
REQ-023 On '*', ENTRY SHALL be set to 0.
REQ-024 On '#', the FSM SHALL copy ENTRY to IR_OUT, set IR_VALID = 1 and clear ENTRY to 0.
REQ-025 A, B, C and D SHALL be ignored.
REQ-026 Key actions SHALL be visible on the outputs in the cycle after the accepting tick.
REQ-027 RE while IR_VALID = 1 SHALL clear IR_VALID and OVERRUN on the next edge; RE while IR_VALID = 0 SHALL have no effect.
REQ-028 '#' while IR_VALID = 1 and RE = 0 SHALL overwrite IR_OUT, keep IR_VALID = 1 and set OVERRUN.
REQ-029 When '#' and RE occur in the same cycle, the FSM SHALL latch the new value with IR_VALID = 1 and OVERRUN = 0.

Reset
REQ-030 RESET low SHALL immediately force: FSM = SCAN, col = 0, COL = 4'b1110, ENTRY = 0, IR_OUT = 0, IR_VALID = 0, OVERRUN = 0, divider = 0, stable counter = 0, synchronizer = 4'b1111.
REQ-031 Reset asserted mid-debounce or mid-release SHALL discard the pending key with no event after release.

Structure
REQ-032 A shared package SHALL hold the scanner state enum, key code constants (KEY_0..KEY_9, KEY_STAR, KEY_HASH, KEY_A..KEY_D) and the row/col-to-key lookup.
REQ-033 The design SHALL contain one sub-module, keypad_scanner (synchronizer, divider, FSM, debounce), outputting a key_valid pulse and a 4-bit key_code; keypad_input_reg SHALL hold the entry and handshake logic.

Verification (CLK_DIV=4, DEBOUNCE_SCANS=2)
REQ-034 Bench SHALL press 1, 2, 8, # (each held and released cleanly) -> ENTRY 1, 12, 128, then IR_OUT=128, IR_VALID=1, ENTRY=0.
REQ-035 Bench SHALL enter 2, 5, 6 -> ENTRY stays 25 after 6 (256 > 255); then 5, # -> IR_OUT=255.
REQ-036 Bench SHALL bounce row 1 low for 1 tick only -> no event; then hold key 5 for 20 ticks -> exactly one event, ENTRY=5.
REQ-037 Bench SHALL enter 7 #, then 9 # with no RE -> IR_OUT=9, IR_VALID=1, OVERRUN=1; then pulse RE -> IR_VALID=0, OVERRUN=0.
REQ-038 Bench SHALL assert RE in the same cycle as a '#' event for value 3 -> IR_OUT=3, IR_VALID=1, OVERRUN=0.
REQ-039 Bench SHALL pull RESET low during PRESS of key 4 -> all outputs at reset values at once, COL=4'b1110, no event after release.
